// File: rtl/demux1_4_tdm_pkg.sv
// Shared types and constants for the 1:4 TDM bit demultiplexer.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef enum logic {
        HUNT,
        LOCK
    } state_t;

    typedef logic [1:0] slot_t;

endpackage

// File: rtl/demux1_4_tdm_if.sv
// Serial-in / parallel-out bundle of the TDM demultiplexer.
interface demux1_4_tdm_if
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);

    logic              in;
    logic              in_valid;
    logic              sync;
    logic [WIDTH-1:0]  out0;
    logic [WIDTH-1:0]  out1;
    logic [WIDTH-1:0]  out2;
    logic [WIDTH-1:0]  out3;
    logic [NUM_CH-1:0] out_valid;
    logic              s1;
    logic              s0;
    logic              locked;
    logic              sync_err;

    modport master (
        output in, in_valid, sync,
        input  out0, out1, out2, out3, out_valid, s1, s0, locked, sync_err
    );

    modport slave (
        input  in, in_valid, sync,
        output out0, out1, out2, out3, out_valid, s1, s0, locked, sync_err
    );

endinterface

// File: rtl/demux1_4_tdm_chan.sv
// One channel: positional shift register plus the registered output word.
module demux_chan #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IW-1:0]    bit_idx,
    input  logic             din,
    input  logic             clr,
    input  logic             load,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] q_q;
    logic             q_valid_q;

    // Clear and write may coincide: a resync beat starts a fresh word at bit 0.
    always_comb begin
        shift_d = clr ? '0 : shift_q;
        if (wr_en) begin
            shift_d[bit_idx] = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            q_valid_q <= load;
            if (load) begin
                q_q <= shift_d;
            end
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: rtl/demux1_4_tdm.sv
// Frame-locking 1:4 TDM demultiplexer: slot/bit counters, framing checks, four channels.
module demux1_4_tdm
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    demux1_4_tdm_if.slave bus
);

    localparam int unsigned   IW   = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t            state_q, state_d;
    slot_t             slot_q, slot_d;
    logic [IW-1:0]     bitcnt_q, bitcnt_d;
    logic              err_q, err_d;
    logic              clr;
    logic [IW-1:0]     bit_idx;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] vld;
    logic [WIDTH-1:0]  q [NUM_CH];

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        bitcnt_d = bitcnt_q;
        err_d    = 1'b0;
        clr      = 1'b0;
        bit_idx  = bitcnt_q;
        wr_en    = '0;
        load     = '0;
        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.sync) begin
                        clr      = 1'b1;
                        wr_en[0] = 1'b1;
                        bit_idx  = '0;
                        slot_d   = 2'd1;
                        bitcnt_d = '0;
                        state_d  = LOCK;
                    end
                end
                LOCK: begin
                    if (slot_q == 2'd0 && !bus.sync) begin
                        // Missing frame marker: drop the beat and re-hunt.
                        err_d    = 1'b1;
                        clr      = 1'b1;
                        slot_d   = 2'd0;
                        bitcnt_d = '0;
                        state_d  = HUNT;
                    end else if (slot_q != 2'd0 && bus.sync) begin
                        // Early marker: realign on this beat as ch0 bit 0.
                        err_d    = 1'b1;
                        clr      = 1'b1;
                        wr_en[0] = 1'b1;
                        bit_idx  = '0;
                        slot_d   = 2'd1;
                        bitcnt_d = '0;
                    end else begin
                        wr_en[slot_q] = 1'b1;
                        load[slot_q]  = (bitcnt_q == LAST);
                        slot_d        = slot_q + 2'd1;
                        if (slot_q == 2'd3) begin
                            bitcnt_d = (bitcnt_q == LAST) ? '0 : bitcnt_q + IW'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            slot_q   <= 2'd0;
            bitcnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            bitcnt_q <= bitcnt_d;
            err_q    <= err_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        demux_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_en  (wr_en[k]),
            .bit_idx(bit_idx),
            .din    (bus.in),
            .clr    (clr),
            .load   (load[k]),
            .q      (q[k]),
            .q_valid(vld[k])
        );
    end

    assign bus.out0      = q[0];
    assign bus.out1      = q[1];
    assign bus.out2      = q[2];
    assign bus.out3      = q[3];
    assign bus.out_valid = vld;
    assign bus.s1        = slot_q[1];
    assign bus.s0        = slot_q[0];
    assign bus.locked    = (state_q == LOCK);
    assign bus.sync_err  = err_q;

endmodule

// File: tb/tb_demux1_4_tdm.sv
// Self-checking bench for demux1_4_tdm: vector table plus framing/reset corner sequences.
module tb_demux1_4_tdm;

    localparam int unsigned W = 8;

    typedef logic [3:0][W-1:0] words_t;

    typedef struct {
        words_t w;
        bit     gaps;
        int     junk;
    } vec_t;

    typedef struct {
        int         ch;
        logic [W-1:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    demux1_4_tdm_if #(.WIDTH(W)) bus ();

    demux1_4_tdm #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   err_seen = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input int ch);
        case (ch)
            0:       return bus.out0;
            1:       return bus.out1;
            2:       return bus.out2;
            default: return bus.out3;
        endcase
    endfunction

    function automatic words_t mk(input logic [W-1:0] a, b, c, d);
        words_t w;
        w[0] = a;
        w[1] = b;
        w[2] = c;
        w[3] = d;
        return w;
    endfunction

    // Every negedge passes through here, so output checking lives in one process.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (bus.out_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(bus.out_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_valid_onehot", 32'(bus.out_valid), 32'(4'b0001 << e.ch));
                    chk("out_word", 32'(pick(e.ch)), 32'(e.word));
                end
            end
            if (bus.sync_err) err_seen++;
        end
    endtask

    task automatic beat(input logic b, input logic s);
        tick();
        bus.in       = b;
        bus.sync     = s;
        bus.in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            bus.in_valid = 1'b0;
            bus.sync     = 1'b0;
        end
    endtask

    task automatic gap3();
        logic [1:0] snap;
        idle(1);
        snap = {bus.s1, bus.s0};
        repeat (2) begin
            idle(1);
            chk("slot_frozen_in_gap", 32'({bus.s1, bus.s0}), 32'(snap));
        end
    endtask

    // Send beats first..last (beat index = frame*4 + slot) of the given words.
    task automatic send_range(input words_t w, input bit gaps, input int first, input int last);
        exp_t e;
        for (int i = first; i <= last; i++) begin
            int f;
            int k;
            f = i / 4;
            k = i % 4;
            beat(w[k][f], k == 0);
            if (f == W - 1) begin
                e.ch   = k;
                e.word = w[k];
                exp_q.push_back(e);
            end
            if (gaps && $urandom_range(0, 3) == 0) gap3();
        end
    endtask

    task automatic check_outs(input string name, input words_t w);
        chk({name, "_out0"}, 32'(bus.out0), 32'(w[0]));
        chk({name, "_out1"}, 32'(bus.out1), 32'(w[1]));
        chk({name, "_out2"}, 32'(bus.out2), 32'(w[2]));
        chk({name, "_out3"}, 32'(bus.out3), 32'(w[3]));
    endtask

    task automatic reset_checks(input string name);
        check_outs(name, '0);
        chk({name, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        chk({name, "_locked"}, 32'(bus.locked), 32'h0);
        chk({name, "_slot"}, 32'({bus.s1, bus.s0}), 32'h0);
        chk({name, "_sync_err"}, 32'(bus.sync_err), 32'h0);
    endtask

    task automatic do_reset(input string name);
        tick();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.sync     = 1'b0;
        #1;
        reset_checks(name);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        err_seen = 0;
    endtask

    localparam int LAST_BEAT = 4 * W - 1;

    vec_t   vecs[4];
    words_t wa, wb, wc;

    initial begin
        bus.in       = 1'b0;
        bus.sync     = 1'b0;
        bus.in_valid = 1'b0;

        vecs[0] = '{w: mk(8'hA5, 8'h3C, 8'hFF, 8'h00), gaps: 1'b0, junk: 0};
        vecs[1] = '{w: mk(8'hA5, 8'h3C, 8'hFF, 8'h00), gaps: 1'b1, junk: 0};
        vecs[2] = '{w: mk(8'hA5, 8'h3C, 8'hFF, 8'h00), gaps: 1'b0, junk: 5};
        vecs[3] = '{w: mk(8'h5A, 8'hC3, 8'h01, 8'h80), gaps: 1'b1, junk: 2};

        for (int v = 0; v < 4; v++) begin
            do_reset("reset");
            for (int j = 0; j < vecs[v].junk; j++) begin
                beat(1'($urandom_range(0, 1)), 1'b0);
                chk("locked_while_hunting", 32'(bus.locked), 32'h0);
            end
            send_range(vecs[v].w, vecs[v].gaps, 0, LAST_BEAT);
            idle(2);
            chk("vec_pending", 32'(exp_q.size()), 32'h0);
            chk("vec_sync_err", 32'(err_seen), 32'h0);
            chk("vec_locked", 32'(bus.locked), 32'h1);
            chk("vec_slot", 32'({bus.s1, bus.s0}), 32'h0);
            check_outs("vec", vecs[v].w);
        end

        // Missing sync on frame 4 slot 0.
        wa = mk(8'hA5, 8'h3C, 8'hFF, 8'h00);
        wb = mk(8'h11, 8'h22, 8'h33, 8'h44);
        do_reset("reset_a");
        send_range(wa, 1'b0, 0, LAST_BEAT);
        send_range(wb, 1'b0, 0, 15);
        beat(wb[0][4], 1'b0);
        idle(1);
        chk("drop_sync_err", 32'(bus.sync_err), 32'h1);
        chk("drop_locked", 32'(bus.locked), 32'h0);
        check_outs("drop_keep", wa);
        idle(1);
        chk("drop_err_single", 32'(bus.sync_err), 32'h0);
        send_range(wb, 1'b0, 0, LAST_BEAT);
        idle(2);
        chk("drop_err_count", 32'(err_seen), 32'h1);
        chk("drop_pending", 32'(exp_q.size()), 32'h0);
        check_outs("drop_recover", wb);

        // Early sync at slot 2 of frame 3 restarts the word.
        do_reset("reset_b");
        send_range(wa, 1'b0, 0, 13);
        beat(wb[0][0], 1'b1);
        idle(1);
        chk("early_sync_err", 32'(bus.sync_err), 32'h1);
        chk("early_locked", 32'(bus.locked), 32'h1);
        chk("early_slot", 32'({bus.s1, bus.s0}), 32'h1);
        send_range(wb, 1'b0, 1, LAST_BEAT);
        idle(2);
        chk("early_err_count", 32'(err_seen), 32'h1);
        chk("early_pending", 32'(exp_q.size()), 32'h0);
        check_outs("early_decode", wb);

        // Asynchronous reset in the middle of frame 6.
        wc = mk(8'h5A, 8'h96, 8'h0F, 8'hF0);
        do_reset("reset_c");
        send_range(wa, 1'b0, 0, LAST_BEAT);
        idle(1);
        check_outs("pre_midreset", wa);
        send_range(wb, 1'b0, 0, 25);
        do_reset("midreset");
        send_range(wc, 1'b0, 0, LAST_BEAT);
        idle(2);
        chk("post_reset_pending", 32'(exp_q.size()), 32'h0);
        chk("post_reset_err", 32'(err_seen), 32'h0);
        check_outs("post_reset", wc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1_4_tdm.md
# demux1_4_tdm

Receive-side counterpart of the 4:1 bit multiplexer. It accepts the serial, time-division-multiplexed bit stream that a 2-bit slot counter plus `mux4_1` produce: slot order i0, i1, i2, i3, with a frame sync marking slot 0. It locks to that stream and rebuilds one WIDTH-bit parallel word per channel. It sits at the far end of the serial link and feeds four independent channel consumers.

## Interface
Parameters:
- WIDTH, 8, bits per channel word (≥2); words travel LSB first, one bit per frame

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in  in  1  serial data bit
- in_valid  in  1  `in`/`sync` sampled this cycle (a "beat")
- sync  in  1  high on the beat carrying the channel-0 bit of every frame
- out0..out3  out  WIDTH each  last complete word of channels 0..3
- out_valid  out  4  bit k pulses one cycle when outk updates
- s1, s0  out  1 each  slot expected for the next beat (mirrors transmitter selects)
- locked  out  1  high in LOCK state
- sync_err  out  1  one-cycle pulse on a framing violation

## Operation
- Frame = 4 beats, slot 0..3 = channel 0..3; word = WIDTH frames; bit index = frame count within the word.
- States:
  - HUNT (reset state): beats without `sync` are ignored. A beat with `sync` stores its bit as ch0 bit 0, sets slot=1 and bitcnt=0, and goes to LOCK.
  - LOCK: each beat writes `in` into the shift register of the current slot at position bitcnt. Slot increments mod 4; bitcnt increments after the slot-3 beat and wraps to 0 after WIDTH-1.
- Word completion: the channel-k beat with bitcnt==WIDTH-1 loads outk with the full word (new bit included) and pulses out_valid[k]. This completes the channels on four consecutive beats.
- Framing checks in LOCK:
  - Slot-0 beat with `sync` low: pulse sync_err, discard all partial words, go to HUNT. The beat is dropped.
  - Beat with `sync` high at slot 1..3: pulse sync_err, discard partial words, and treat the beat as a fresh ch0 bit 0 (slot=1, bitcnt=0). Stay in LOCK.
- in_valid low: no state, slot, bitcnt or shift change.
- out0..out3 hold their value until the next completion. Partial words never reach the outputs.
- s1,s0 = {slot[1], slot[0]}; they read 00 in HUNT.

## Timing
- Reset values: out0..out3=0, out_valid=0, s1=s0=0, locked=0, sync_err=0. Internal state is HUNT, slot=0, bitcnt=0, shift registers=0.
- rst_n low clears everything immediately, including in the middle of a word. After release the block starts in HUNT, and the first valid `sync` beat is accepted on the first rising edge with rst_n high.
- Latency: outk, out_valid[k] and sync_err are registered and appear the cycle after the accepting edge. locked rises the cycle after the sync beat.
- Back-to-back beats every cycle are supported at full rate with no bubbles.
- Simultaneous word completion and framing error cannot occur on the same beat, because completion requires a correct slot. An error discards only partial words, never words already on the outputs.

## Structure
- Package demux_pkg:
  - NUM_CH=4
  - state enum {HUNT, LOCK}
  - 2-bit slot_t
- Sub-module demux_chan (parameter WIDTH), instantiated four times. Ports: clk, rst_n, wr_en, bit_idx, din, clr, load, q, q_valid. It contains the channel shift register and output register.
- The top level holds the FSM, slot/bitcnt counters and error logic.

## Test plan
All scenarios use WIDTH=8.
- Continuous stream of 8 frames encoding ch0=8'hA5, ch1=8'h3C, ch2=8'hFF, ch3=8'h00 -> out0..out3 equal those values; out_valid pulses 0001, 0010, 0100, 1000 on four consecutive cycles; sync_err never pulses.
- Same stream with in_valid low for 3 cycles between random beats -> identical outputs; s1/s0 frozen during gaps.
- 5 beats with sync=0 before the first sync -> all ignored, locked stays 0 until the sync beat, outputs as in the first scenario.
- Drop sync on frame 4 slot 0 -> sync_err one pulse, locked=0, outputs keep the previous words; the next full 8-frame sequence decodes correctly.
- Sync asserted at slot 2 of frame 3 -> sync_err pulse, locked stays 1, decoding restarts from that beat as ch0 bit 0.
- rst_n low for 1 cycle during frame 6 -> all outputs 0 at once, locked=0; a fresh sequence decodes ch0=8'h5A.
